// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetches one instruction per accepted enable step and drives register-file strobes.
// Latency: write and branch instructions update instruction_pointer 3 cycles after the enable cycle, NOPs after 2 (WAIT_DIN time extra).
// Backpressure: WAIT_DIN stalls until din_valid; enable pulses arriving outside IDLE are dropped, never queued.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   enable              step pulse; starts one instruction when the sequencer is IDLE
//   instruction[31:0]   word at instruction_pointer: [31:29] group, [28:26] command, [7:0] target address
//   flags[7:0]          flag byte, bit selected by the latched command for conditional jumps
//   din_valid           external input byte available
//   instruction_pointer registered program address
//   write_enable        one-cycle register-file write strobe (WRITEBACK only)
//   write_sel           write-data source: 0 = ALU, 1 = din
//   din_ack             one-cycle acknowledge that din was consumed
//   halted              high while in HALT
//   state[2:0]          FSM state, for debug
module cpu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] instruction,
  input  logic [7:0]  flags,
  input  logic        din_valid,
  output logic [7:0]  instruction_pointer,
  output logic        write_enable,
  output logic        write_sel,
  output logic        din_ack,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WAIT_DIN  = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_BRANCH    = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] ip_q, ip_d;
  logic [2:0] group_q, group_d;
  logic [2:0] cmd_q, cmd_d;
  logic [7:0] addr_q, addr_d;
  logic       write_sel_q, write_sel_d;

  // Operand bits between the command and the address are not used by the sequencer.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[25:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ip_q        <= 8'h00;
      group_q     <= 3'd0;
      cmd_q       <= 3'd0;
      addr_q      <= 8'h00;
      write_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      group_q     <= group_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      write_sel_q <= write_sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    group_d     = group_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    write_sel_d = write_sel_q;
    din_ack     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        write_sel_d = 1'b0;
        if (enable) begin
          group_d = instruction[31:29];
          cmd_d   = instruction[28:26];
          addr_d  = instruction[7:0];
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (group_q)
          3'd0, 3'd1: begin
            write_sel_d = 1'b0;
            state_d     = ST_WRITEBACK;
          end
          3'd2:       state_d = ST_WAIT_DIN;
          3'd3, 3'd4: state_d = ST_BRANCH;
          3'd7:       state_d = ST_HALT;
          default: begin
            // Groups 5 and 6 are NOPs: retire straight from decode.
            ip_d    = ip_q + 8'd1;
            state_d = ST_IDLE;
          end
        endcase
      end

      ST_WAIT_DIN: begin
        // din_ack is combinational so it coincides with the cycle din is taken
        // and cannot overlap the write strobe of the following WRITEBACK.
        if (din_valid) begin
          din_ack     = 1'b1;
          write_sel_d = 1'b1;
          state_d     = ST_WRITEBACK;
        end
      end

      ST_WRITEBACK: begin
        ip_d        = ip_q + 8'd1;
        write_sel_d = 1'b0;
        state_d     = ST_IDLE;
      end

      ST_BRANCH: begin
        // Only groups 3 (unconditional) and 4 (flag-conditional) reach here.
        if (group_q == 3'd3 || flags[cmd_q]) begin
          ip_d = addr_q;
        end else begin
          ip_d = ip_q + 8'd1;
        end
        state_d = ST_IDLE;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_IDLE;
    endcase
  end

  assign instruction_pointer = ip_q;
  assign write_enable        = (state_q == ST_WRITEBACK);
  assign write_sel           = write_sel_q;
  assign halted              = (state_q == ST_HALT);
  assign state               = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: instruction-level reference model feeds a scoreboard,
// a negedge monitor pops expectations whenever the DUT strobes or retires an instruction.
// Directed cases for jumps, wrap, halt and reset, then a randomized program run.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, din_valid;
  logic [31:0] instruction;
  logic [7:0]  flags;
  logic [7:0]  instruction_pointer;
  logic        write_enable, write_sel, din_ack, halted;
  logic [2:0]  state;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .instruction         (instruction),
    .flags               (flags),
    .din_valid           (din_valid),
    .instruction_pointer (instruction_pointer),
    .write_enable        (write_enable),
    .write_sel           (write_sel),
    .din_ack             (din_ack),
    .halted              (halted),
    .state               (state)
  );

  logic [31:0] mem [256];
  assign instruction = mem[instruction_pointer];

  typedef struct {
    bit         halt;
    logic [7:0] ip;
    int         lat;
  } exp_t;

  exp_t done_q[$];
  bit   sel_q[$];
  bit   ack_q[$];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] model_ip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] mk(input int g, input int c, input logic [7:0] a);
    logic [2:0] g3, c3;
    g3 = g[2:0];
    c3 = c[2:0];
    return {g3, c3, 18'd0, a};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: decoupled from the driver, consumes expectations as DUT events appear.
  initial begin
    logic [2:0] prev_state;
    int         acc_cyc, wait_cnt;
    exp_t       e;
    prev_state = 3'd0;
    acc_cyc    = 0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_state = 3'd0;
        wait_cnt   = 0;
      end else begin
        check("we_ack_exclusive", 32'(write_enable & din_ack), 32'd0);
        if (state == 3'd0) check("write_sel_idle", 32'(write_sel), 32'd0);
        if (write_enable) begin
          check("we_in_writeback", 32'(state), 32'd3);
          if (sel_q.size() == 0) unexpected("write_enable_unexpected");
          else check("write_sel", 32'(write_sel), 32'(sel_q.pop_front()));
        end
        if (din_ack) begin
          check("din_ack_in_wait_din", 32'(state), 32'd2);
          if (ack_q.size() == 0) unexpected("din_ack_unexpected");
          else void'(ack_q.pop_front());
        end
        if (state != 3'd0 && prev_state == 3'd0) begin
          acc_cyc  = cyc;
          wait_cnt = 0;
        end
        if (state == 3'd2) wait_cnt++;
        if ((state == 3'd0 && prev_state != 3'd0) || (state == 3'd5 && prev_state != 3'd5)) begin
          if (done_q.size() == 0) unexpected("retire_unexpected");
          else begin
            e = done_q.pop_front();
            check("retire_is_halt", 32'(state == 3'd5), 32'(e.halt));
            check("ip_after_instr", 32'(instruction_pointer), 32'(e.ip));
            if (!e.halt) check("latency", 32'(cyc - acc_cyc + 1 - wait_cnt), 32'(e.lat));
          end
        end
        prev_state = state;
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    din_valid = 1'b0;
    done_q.delete();
    sel_q.delete();
    ack_q.delete();
    model_ip = 8'h00;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ip", 32'(instruction_pointer), 32'd0);
    check("rst_write_enable", 32'(write_enable), 32'd0);
    check("rst_write_sel", 32'(write_sel), 32'd0);
    check("rst_din_ack", 32'(din_ack), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] target);
    for (int i = 0; i < 64 && state != target; i++) begin
      @(posedge clk);
      #1;
    end
    if (state != target) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout actual=%0d required=%0d", state, target);
      do_reset();
    end
  endtask

  // Called at posedge+1 with the DUT idle. The model works per instruction from
  // the group rules; the DUT fetches the word from mem at its own ip.
  task automatic run_instr(input logic [31:0] instr, input logic [7:0] fl, input int delay, input bit extra_en);
    logic [2:0] g, c;
    logic [7:0] a, nxt;
    int         lat;
    g = instr[31:29];
    c = instr[28:26];
    a = instr[7:0];
    mem[model_ip] = instr;
    flags         = fl;
    din_valid     = (g == 3'd2) ? 1'b0 : 1'($urandom_range(0, 1));
    lat           = 3;
    nxt           = model_ip + 8'd1;
    case (g)
      3'd0, 3'd1: sel_q.push_back(1'b0);
      3'd2: begin
        ack_q.push_back(1'b1);
        sel_q.push_back(1'b1);
      end
      3'd3: nxt = a;
      3'd4: if (fl[c]) nxt = a;
      3'd7: nxt = model_ip;
      default: lat = 2;
    endcase
    done_q.push_back('{halt: (g == 3'd7), ip: nxt, lat: lat});

    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = extra_en;   // lands in DECODE and must be dropped
    @(posedge clk);
    #1;
    enable = 1'b0;
    if (g == 3'd2) begin
      for (int i = 0; i < delay; i++) begin
        check("wait_din_hold", 32'(state), 32'd2);
        @(posedge clk);
        #1;
      end
      din_valid = 1'b1;
    end
    wait_state((g == 3'd7) ? 3'd5 : 3'd0);
    din_valid = 1'b0;
    model_ip  = nxt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  frozen;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    flags = 8'h00;
    do_reset();

    // ALU at ip 0, then input with a 10-cycle din stall
    run_instr(mk(1, 2, 8'h33), 8'h00, 0, 1'b0);
    run_instr(mk(2, 0, 8'h00), 8'h00, 10, 1'b0);
    // conditional jump on flags[3], taken then not taken
    run_instr(mk(4, 3, 8'h40), 8'h08, 0, 1'b0);
    run_instr(mk(4, 3, 8'h40), 8'h00, 0, 1'b0);
    // jump to FF, jump FF->10, back to FF, then NOP at FF wraps to 00
    run_instr(mk(3, 0, 8'hFF), 8'h00, 0, 1'b0);
    run_instr(mk(3, 0, 8'h10), 8'h00, 0, 1'b0);
    run_instr(mk(3, 0, 8'hFF), 8'h00, 0, 1'b0);
    run_instr(mk(5, 0, 8'h00), 8'h00, 0, 1'b1);
    check("wrap_ip", 32'(instruction_pointer), 32'h00);

    // randomized program, no halts
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      r[31:29] = 3'($urandom_range(0, 6));
      run_instr(r, 8'($urandom), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    // halt is absorbing
    run_instr(mk(7, 0, 8'h00), 8'h00, 0, 1'b0);
    frozen = model_ip;
    for (int i = 0; i < 5; i++) begin
      enable    = 1'b1;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      enable    = 1'b0;
      din_valid = 1'b0;
      @(posedge clk);
      #1;
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_state", 32'(state), 32'd5);
      check("halt_ip_frozen", 32'(instruction_pointer), 32'(frozen));
    end
    do_reset();

    // reset while in WAIT_DIN with din_valid rising in the same cycle
    mem[0] = mk(2, 0, 8'h00);
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_wait_din", 32'(state), 32'd2);
    din_valid = 1'b1;
    reset     = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_din_ack", 32'(din_ack), 32'd0);
    check("abort_write_enable", 32'(write_enable), 32'd0);
    do_reset();

    // first fetch after reset comes from address 0
    run_instr(mk(6, 0, 8'h00), 8'h00, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("left_retire", 32'(done_q.size()), 32'd0);
    check("left_write", 32'(sel_q.size()), 32'd0);
    check("left_ack", 32'(ack_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 Port reset  input  1  asynchronous, active-high reset.
REQ-003 Port enable  input  1  step pulse from the turbo/clock divider; one instruction is started per accepted pulse.
REQ-004 Port instruction  input  32  current instruction word, addressed by instruction_pointer.
  - Fields: [31:29] command_group; [28:26] command; [7:0] target address.
REQ-005 Port flags  input  8  register-file flag byte used by conditional jumps.
REQ-006 Port din_valid  input  1  external data input has a byte ready.
REQ-007 Port instruction_pointer  output  8  program address, registered.
REQ-008 Port write_enable  output  1  register-file write strobe, one cycle wide.
REQ-009 Port write_sel  output  1  write-data source: 0 = ALU result, 1 = din.
REQ-010 Port din_ack  output  1  one-cycle acknowledge that din has been consumed.
REQ-011 Port halted  output  1  high while the sequencer is in HALT.
REQ-012 Port state  output  3  current FSM state encoding, for debug.

Function
REQ-013 The FSM SHALL have these states and encodings: IDLE=0, DECODE=1, WAIT_DIN=2, WRITEBACK=3, BRANCH=4, HALT=5.
REQ-014 IDLE SHALL wait for enable=1; on that edge it SHALL latch command_group, command and address into internal registers and go to DECODE.
REQ-015 DECODE SHALL dispatch on the latched group:
  - groups 0 and 1 (move/ALU) -> WRITEBACK with write_sel=0;
  - group 2 (input) -> WAIT_DIN;
  - groups 3 and 4 (jump/conditional jump) -> BRANCH;
  - group 7 -> HALT;
  - groups 5 and 6 -> IDLE with instruction_pointer+1 (NOP).
REQ-016 WAIT_DIN SHALL stay in place while din_valid=0, ignoring enable.
  - When din_valid=1 it SHALL pulse din_ack for one cycle, set write_sel=1 and go to WRITEBACK.
REQ-017 WRITEBACK SHALL assert write_enable for exactly one cycle, increment instruction_pointer, and return to IDLE.
REQ-018 BRANCH SHALL return to IDLE and update instruction_pointer as follows:
  - group 3: load the latched address unconditionally;
  - group 4: load the address if flags[command] = 1, otherwise increment.
REQ-019 instruction_pointer SHALL wrap modulo 256: 8'hFF + 1 = 8'h00, with no status flag.
REQ-020 HALT SHALL be absorbing: ignore enable and din_valid, keep halted=1, hold instruction_pointer; only reset leaves it.
REQ-021 Latency from an accepted enable edge to the new instruction_pointer value, excluding time spent in WAIT_DIN:
  - 3 cycles for write instructions;
  - 3 cycles for branches;
  - 2 cycles for NOPs.
REQ-022 An enable pulse arriving in any state other than IDLE SHALL be dropped, not queued.
REQ-023 write_enable and din_ack SHALL never be asserted in the same cycle.
REQ-024 write_enable SHALL never be asserted outside WRITEBACK.
REQ-025 write_sel SHALL hold its value from DECODE/WAIT_DIN through WRITEBACK, then return to 0 in IDLE.

Reset
REQ-026 While reset=1, independent of clk, the block SHALL force these values:
  - state=IDLE;
  - instruction_pointer=8'h00;
  - write_enable=0, write_sel=0, din_ack=0, halted=0;
  - latched fields cleared to 0.
REQ-027 Reset asserted mid-operation, including WAIT_DIN and HALT, SHALL abort the instruction with no write_enable or din_ack pulse.
REQ-028 The first enable edge after reset release SHALL fetch address 0.

Verification
REQ-029 ALU instruction (group 1) at ip=0, single enable pulse -> exactly one write_enable pulse with write_sel=0; ip=1 three cycles after the enable edge.
REQ-030 Input instruction (group 2), din_valid held low for 10 cycles then raised -> state stays 2 for those 10 cycles; one din_ack, then one write_enable with write_sel=1; ip increments once.
REQ-031 Conditional jump, group 4, command=3, address=8'h40:
  - flags=8'h08 -> ip=8'h40;
  - flags=8'h00 -> ip=old+1.
REQ-032 Unconditional jump at ip=8'hFF to 8'h10, followed by a NOP at ip=8'hFF reached via branch -> ip=8'h10; the NOP at 8'hFF gives ip=8'h00 (wrap).
REQ-033 Halt instruction then 5 enable pulses -> halted=1, state=5, ip frozen, no write_enable; reset -> ip=0, halted=0.
REQ-034 Reset asserted during WAIT_DIN with din_valid=1 in the same cycle -> no din_ack, no write_enable, state=0 immediately.
